// File: rtl/dac_spi_out.sv
// dac_spi_out: register-programmed sample pacer that ships 16-bit frames to a 12-bit SPI DAC.
// Build option: define DAC_SPI_SAT_EN to clamp samples above 4095 instead of wrapping them.
module dac_spi_out (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] sample,
    output logic        dac_cs_n,
    output logic        dac_sck,
    output logic        dac_mosi,
    output logic        dac_ldac_n,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    logic        wr_en;
    logic [1:0]  sel;
    logic        ctrl_en;
    logic        ctrl_buf;
    logic        ctrl_ga_n;
    logic [7:0]  div_reg;
    logic [15:0] rate_reg;
    logic [15:0] rate_cnt;
    logic [15:0] rate_last;
    logic [7:0]  ovr_cnt;
    logic [7:0]  ovr_base;
    logic        tick;
    logic        drop;
    logic        busy;
    logic [1:0]  state;
    logic [7:0]  div_q;
    logic [7:0]  hcnt;
    logic [4:0]  half_idx;
    logic [15:0] shreg;
    logic [15:0] frame_word;
    logic [11:0] sample_data;
    logic        unused_bits;

    // Bus writes are single-cycle with no valid/ready: any wstrb bit set commits wdata
    // to the register chosen by addr[3:2] on that clock edge; reads are combinational.
    assign wr_en     = |wstrb;
    assign sel       = addr[3:2];
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_en   <= 1'b0;
            ctrl_buf  <= 1'b0;
            ctrl_ga_n <= 1'b1;
            div_reg   <= 8'd1;
            rate_reg  <= 16'd1000;
        end else if (wr_en) begin
            case (sel)
                2'd0: begin
                    ctrl_en   <= wdata[0];
                    ctrl_buf  <= wdata[1];
                    ctrl_ga_n <= wdata[2];
                end
                2'd1:    div_reg  <= wdata[7:0];
                2'd2:    rate_reg <= wdata[15:0];
                default: begin end
            endcase
        end
    end

    // RATE of zero behaves like one: a tick every cycle.
    assign rate_last = (rate_reg == 16'd0) ? 16'd0 : rate_reg - 16'd1;
    assign tick      = ctrl_en && (rate_cnt == rate_last);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rate_cnt <= 16'd0;
        end else if (!ctrl_en || (wr_en && sel == 2'd2) || tick) begin
            rate_cnt <= 16'd0;
        end else begin
            rate_cnt <= rate_cnt + 16'd1;
        end
    end

    // A STATUS write and a dropped tick in the same cycle leave a count of one.
    assign drop     = tick && busy;
    assign ovr_base = (wr_en && sel == 2'd3) ? 8'd0 : ovr_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovr_cnt <= 8'd0;
        end else if (drop && ovr_base != 8'hFF) begin
            ovr_cnt <= ovr_base + 8'd1;
        end else begin
            ovr_cnt <= ovr_base;
        end
    end

`ifdef DAC_SPI_SAT_EN
    assign sample_data = (sample > 32'd4095) ? 12'hFFF : sample[11:0];
`else
    assign sample_data = sample[11:0];
`endif

    assign frame_word  = {1'b0, ctrl_buf, ctrl_ga_n, 1'b1, sample_data};
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16], sample[31:12]};

    // half_idx counts SCK half-periods: even = low phase (data set up), odd = high phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            div_q      <= 8'd0;
            hcnt       <= 8'd0;
            half_idx   <= 5'd0;
            shreg      <= 16'd0;
            dac_cs_n   <= 1'b1;
            dac_sck    <= 1'b0;
            dac_mosi   <= 1'b0;
            dac_ldac_n <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state    <= ST_SHIFT;
                        div_q    <= div_reg;
                        hcnt     <= 8'd0;
                        half_idx <= 5'd0;
                        shreg    <= frame_word;
                        dac_cs_n <= 1'b0;
                        dac_mosi <= frame_word[15];
                    end
                end
                ST_SHIFT: begin
                    if (hcnt == div_q) begin
                        hcnt     <= 8'd0;
                        half_idx <= half_idx + 5'd1;
                        if (half_idx == 5'd31) begin
                            state    <= ST_HOLD;
                            dac_cs_n <= 1'b1;
                            dac_sck  <= 1'b0;
                            dac_mosi <= 1'b0;
                        end else if (!half_idx[0]) begin
                            dac_sck <= 1'b1;
                        end else begin
                            dac_sck  <= 1'b0;
                            shreg    <= {shreg[14:0], 1'b0};
                            dac_mosi <= shreg[14];
                        end
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (hcnt == div_q) begin
                        hcnt       <= 8'd0;
                        state      <= ST_LATCH;
                        dac_ldac_n <= 1'b0;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                ST_LATCH: begin
                    if (hcnt == div_q) begin
                        hcnt       <= 8'd0;
                        state      <= ST_IDLE;
                        dac_ldac_n <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (sel)
            2'd0:    rdata = {29'd0, ctrl_ga_n, ctrl_buf, ctrl_en};
            2'd1:    rdata = {24'd0, div_reg};
            2'd2:    rdata = {16'd0, rate_reg};
            default: rdata = {16'd0, ovr_cnt, 7'd0, busy};
        endcase
    end

endmodule

// File: tb/tb_dac_spi_out.sv
// Bench for dac_spi_out: an SPI monitor decodes frames and timing, tasks compare them to
// values derived from the register settings. Honours DAC_SPI_SAT_EN like the design.
module tb_dac_spi_out;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] sample;
    logic        dac_cs_n;
    logic        dac_sck;
    logic        dac_mosi;
    logic        dac_ldac_n;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    dac_spi_out dut (
        .clk(clk), .resetn(resetn), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .rdata(rdata), .sample(sample), .dac_cs_n(dac_cs_n), .dac_sck(dac_sck),
        .dac_mosi(dac_mosi), .dac_ldac_n(dac_ldac_n), .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_word_q[$];
    int          got_bits_q[$];
    int          got_cs_q[$];
    int          got_per_q[$];
    int          got_ldac_q[$];
    int          got_start_q[$];

    int          mon_ldac = 0;
    int          mon_nbits = 0;
    int          sck_bad = 0;
    bit          in_frame = 1'b0;
    logic [15:0] mon_word = 16'd0;
    int          cs_cnt = 0;
    int          per = 0;
    int          last_rise = -1;
    int          ldac_cnt = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b0;
    logic        prev_ldac = 1'b1;

    // SPI monitor: samples pins on the falling clock edge, away from the DUT's active edge.
    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            in_frame = 1'b0;
            ldac_cnt = 0;
        end else begin
            if (prev_cs && !dac_cs_n) begin
                in_frame = 1'b1; mon_nbits = 0; mon_word = 16'd0;
                cs_cnt = 0; per = 0; last_rise = -1;
                got_start_q.push_back(cyc);
            end
            if (!dac_cs_n) cs_cnt++;
            if (dac_cs_n && dac_sck) sck_bad++;
            if (!dac_cs_n && !prev_sck && dac_sck) begin
                mon_word = {mon_word[14:0], dac_mosi};
                mon_nbits++;
                if (last_rise >= 0 && per == 0) per = cyc - last_rise;
                last_rise = cyc;
            end
            if (!prev_cs && dac_cs_n && in_frame) begin
                in_frame = 1'b0;
                got_word_q.push_back(mon_word);
                got_bits_q.push_back(mon_nbits);
                got_cs_q.push_back(cs_cnt);
                got_per_q.push_back(per);
            end
            if (!dac_ldac_n) ldac_cnt++;
            if (!prev_ldac && dac_ldac_n) begin
                got_ldac_q.push_back(ldac_cnt);
                ldac_cnt = 0;
                mon_ldac++;
            end
        end
        prev_cs = dac_cs_n;
        prev_sck = dac_sck;
        prev_ldac = dac_ldac_n;
    end

    // Reference: frame = {0, BUF, GA_N, 1, 12-bit data}; data wraps or clamps per build.
    function automatic logic [15:0] exp_word(input bit b, input bit g, input logic [31:0] s);
        logic [11:0] d;
`ifdef DAC_SPI_SAT_EN
        d = (s > 32'd4095) ? 12'hFFF : s[11:0];
`else
        d = s[11:0];
`endif
        return {1'b0, b, g, 1'b1, d};
    endfunction

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        addr = {28'd0, r, 2'b00};
        wdata = d;
        wstrb = 4'($urandom_range(1, 15));
        @(negedge clk);
        wstrb = 4'd0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        @(negedge clk);
        addr = {28'd0, r, 2'b00};
        #1 d = rdata;
    endtask

    task automatic flush();
        exp_q.delete(); got_word_q.delete(); got_bits_q.delete(); got_cs_q.delete();
        got_per_q.delete(); got_ldac_q.delete(); got_start_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_ldac_q.size() >= n && got_word_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_start_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_bits(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (in_frame && mon_nbits >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic stop_and_idle();
        bit ok;
        bus_write(2'd0, 32'h4);
        repeat (3) @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (dbg_state == 2'd0 && dac_ldac_n == 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL idle_timeout state=%0d exp=0", dbg_state); end
        repeat (2) @(negedge clk);
        flush();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_regs [4];
        exp_regs[0] = 32'h4; exp_regs[1] = 32'd1; exp_regs[2] = 32'd1000; exp_regs[3] = 32'd0;
        checks++; if (dac_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%0b exp=1", dac_cs_n); end
        checks++; if (dac_sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%0b exp=0", dac_sck); end
        checks++; if (dac_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%0b exp=0", dac_mosi); end
        checks++; if (dac_ldac_n !== 1'b1) begin failures++; $display("FAIL reset_ldac_n got=%0b exp=1", dac_ldac_n); end
        @(negedge clk);
        resetn = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bus_read(2'(r), rd);
            checks++;
            if (rd !== exp_regs[r]) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", r, rd, exp_regs[r]); end
        end
    endtask

    task automatic test_basic_frame();
        bit ok;
        logic [15:0] w;
        stop_and_idle();
        bus_write(2'd1, 32'd1);
        bus_write(2'd2, 32'd200);
        sample = 32'h0000_0ABC;
        bus_write(2'd0, 32'h5);
        w = exp_word(1'b0, 1'b1, sample);
        exp_q.push_back(w); exp_q.push_back(w);
        wait_frames(2, 800, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_timeout frames=%0d exp=2", got_ldac_q.size()); end
        if (ok) begin
            checks++;
            if (got_start_q[1] - got_start_q[0] !== 200) begin
                failures++; $display("FAIL basic_interval got=%0d exp=200", got_start_q[1] - got_start_q[0]);
            end
            for (int k = 0; k < 2; k++) begin
                w = exp_q.pop_front();
                checks++; if (got_word_q[k] !== w) begin failures++; $display("FAIL basic_word got=%h exp=%h", got_word_q[k], w); end
                checks++; if (got_bits_q[k] !== 16) begin failures++; $display("FAIL basic_bits got=%0d exp=16", got_bits_q[k]); end
                checks++; if (got_per_q[k] !== 4) begin failures++; $display("FAIL basic_sck_period got=%0d exp=4", got_per_q[k]); end
                checks++; if (got_cs_q[k] !== 64) begin failures++; $display("FAIL basic_cs_low got=%0d exp=64", got_cs_q[k]); end
                checks++; if (got_ldac_q[k] !== 2) begin failures++; $display("FAIL basic_ldac_low got=%0d exp=2", got_ldac_q[k]); end
            end
        end
    endtask

    task automatic test_sample_format();
        bit ok;
        logic [15:0] w;
        stop_and_idle();
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd100);
        sample = 32'h0000_1234;
        bus_write(2'd0, 32'h7);
        w = exp_word(1'b1, 1'b1, sample);
        wait_frames(1, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL fmt_timeout frames=%0d exp=1", got_ldac_q.size()); end
        if (ok) begin
            checks++; if (got_word_q[0] !== w) begin failures++; $display("FAIL fmt_word got=%h exp=%h", got_word_q[0], w); end
            checks++; if (got_per_q[0] !== 2) begin failures++; $display("FAIL fmt_sck_period got=%0d exp=2", got_per_q[0]); end
            checks++; if (got_cs_q[0] !== 32) begin failures++; $display("FAIL fmt_cs_low got=%0d exp=32", got_cs_q[0]); end
            checks++; if (got_ldac_q[0] !== 1) begin failures++; $display("FAIL fmt_ldac_low got=%0d exp=1", got_ldac_q[0]); end
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        int d, h, r;
        bit b, g;
        logic [31:0] s;
        logic [15:0] w;
        for (int it = 0; it < 5; it++) begin
            stop_and_idle();
            d = $urandom_range(0, 3);
            h = d + 1;
            r = 34 * h + $urandom_range(4, 40);
            b = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 4095)) : $urandom();
            bus_write(2'd1, 32'(d));
            bus_write(2'd2, 32'(r));
            sample = s;
            bus_write(2'd0, {29'd0, g, b, 1'b1});
            exp_q.push_back(exp_word(b, g, s)); exp_q.push_back(exp_word(b, g, s));
            wait_frames(2, 3 * r + 200, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL rand_timeout it=%0d frames=%0d exp=2", it, got_ldac_q.size()); end
            if (ok) begin
                checks++;
                if (got_start_q[1] - got_start_q[0] !== r) begin
                    failures++; $display("FAIL rand_interval got=%0d exp=%0d", got_start_q[1] - got_start_q[0], r);
                end
                for (int k = 0; k < 2; k++) begin
                    w = exp_q.pop_front();
                    checks++; if (got_word_q[k] !== w) begin failures++; $display("FAIL rand_word got=%h exp=%h", got_word_q[k], w); end
                    checks++; if (got_per_q[k] !== 2 * h) begin failures++; $display("FAIL rand_sck_period got=%0d exp=%0d", got_per_q[k], 2 * h); end
                    checks++; if (got_cs_q[k] !== 32 * h) begin failures++; $display("FAIL rand_cs_low got=%0d exp=%0d", got_cs_q[k], 32 * h); end
                    checks++; if (got_ldac_q[k] !== h) begin failures++; $display("FAIL rand_ldac_low got=%0d exp=%0d", got_ldac_q[k], h); end
                end
            end
        end
    endtask

    task automatic test_latch_boundary();
        bit ok;
        logic [31:0] rd;
        stop_and_idle();
        bus_write(2'd3, 32'd0);
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd34);
        sample = 32'($urandom_range(0, 4095));
        bus_write(2'd0, 32'h5);
        wait_starts(3, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL latch_timeout starts=%0d exp=3", got_start_q.size()); end
        if (ok) begin
            bus_read(2'd3, rd);
            checks++; if (rd[15:8] !== 8'd2) begin failures++; $display("FAIL latch_overrun got=%0d exp=2", rd[15:8]); end
            checks++;
            if (got_start_q[2] - got_start_q[1] !== 68) begin
                failures++; $display("FAIL latch_interval got=%0d exp=68", got_start_q[2] - got_start_q[1]);
            end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        logic [31:0] rd;
        stop_and_idle();
        bus_write(2'd3, 32'd0);
        bus_write(2'd1, 32'd3);
        bus_write(2'd2, 32'd20);
        bus_write(2'd0, 32'h5);
        wait_starts(3, 1000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ovr_timeout starts=%0d exp=3", got_start_q.size()); end
        bus_read(2'd3, rd);
        checks++; if (rd[15:8] !== 8'd12) begin failures++; $display("FAIL ovr_count got=%0d exp=12", rd[15:8]); end
        checks++; if (rd[0] !== 1'b1) begin failures++; $display("FAIL ovr_busy got=%0b exp=1", rd[0]); end
        wait_starts(46, 8000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ovr_sat_timeout starts=%0d exp=46", got_start_q.size()); end
        bus_read(2'd3, rd);
        checks++; if (rd[15:8] !== 8'd255) begin failures++; $display("FAIL ovr_saturate got=%0d exp=255", rd[15:8]); end
        bus_write(2'd3, 32'd0);
        bus_read(2'd3, rd);
        checks++; if (rd[15:8] !== 8'd0) begin failures++; $display("FAIL ovr_clear got=%0d exp=0", rd[15:8]); end
    endtask

    task automatic test_en_clear();
        bit ok;
        bit b;
        int l0;
        logic [31:0] rd;
        logic [15:0] w;
        stop_and_idle();
        b = 1'($urandom_range(0, 1));
        bus_write(2'd1, 32'd1);
        bus_write(2'd2, 32'd200);
        sample = $urandom();
        w = exp_word(b, 1'b1, sample);
        bus_write(2'd0, {29'd0, 1'b1, b, 1'b1});
        wait_bits(5, 600, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL enclr_start_timeout bits=%0d exp=5", mon_nbits); end
        l0 = mon_ldac;
        bus_write(2'd0, {29'd0, 1'b1, b, 1'b0});
        wait_frames(1, 400, ok);
        repeat (450) @(negedge clk);
        checks++; if (mon_ldac - l0 !== 1) begin failures++; $display("FAIL enclr_ldac_pulses got=%0d exp=1", mon_ldac - l0); end
        checks++; if (got_start_q.size() !== 1) begin failures++; $display("FAIL enclr_frames got=%0d exp=1", got_start_q.size()); end
        if (ok) begin
            checks++; if (got_word_q[0] !== w) begin failures++; $display("FAIL enclr_word got=%h exp=%h", got_word_q[0], w); end
        end
        bus_read(2'd3, rd);
        checks++; if (rd[0] !== 1'b0) begin failures++; $display("FAIL enclr_busy got=%0b exp=0", rd[0]); end
        checks++;
        if ({dac_cs_n, dac_sck, dac_ldac_n} !== 3'b101) begin
            failures++; $display("FAIL enclr_idle_lines got=%b exp=101", {dac_cs_n, dac_sck, dac_ldac_n});
        end
    endtask

    task automatic test_div_change();
        bit ok;
        stop_and_idle();
        bus_write(2'd1, 32'd1);
        bus_write(2'd2, 32'd200);
        sample = $urandom();
        bus_write(2'd0, 32'h5);
        wait_bits(3, 600, ok);
        bus_write(2'd1, 32'd7);
        wait_frames(2, 1500, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL div_timeout frames=%0d exp=2", got_ldac_q.size()); end
        if (ok) begin
            checks++; if (got_per_q[0] !== 4) begin failures++; $display("FAIL div_cur_period got=%0d exp=4", got_per_q[0]); end
            checks++; if (got_ldac_q[0] !== 2) begin failures++; $display("FAIL div_cur_ldac got=%0d exp=2", got_ldac_q[0]); end
            checks++; if (got_per_q[1] !== 16) begin failures++; $display("FAIL div_next_period got=%0d exp=16", got_per_q[1]); end
            checks++; if (got_cs_q[1] !== 256) begin failures++; $display("FAIL div_next_cs_low got=%0d exp=256", got_cs_q[1]); end
            checks++; if (got_ldac_q[1] !== 8) begin failures++; $display("FAIL div_next_ldac got=%0d exp=8", got_ldac_q[1]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int l0;
        logic [31:0] rd;
        logic [31:0] exp_regs [4];
        exp_regs[0] = 32'h4; exp_regs[1] = 32'd1; exp_regs[2] = 32'd1000; exp_regs[3] = 32'd0;
        stop_and_idle();
        bus_write(2'd1, 32'd1);
        bus_write(2'd2, 32'd200);
        sample = $urandom();
        bus_write(2'd0, 32'h5);
        wait_bits(8, 600, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_start_timeout bits=%0d exp=8", mon_nbits); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (dac_cs_n !== 1'b1) begin failures++; $display("FAIL rstmid_cs_n got=%0b exp=1", dac_cs_n); end
        checks++; if (dac_sck !== 1'b0) begin failures++; $display("FAIL rstmid_sck got=%0b exp=0", dac_sck); end
        checks++; if (dac_ldac_n !== 1'b1) begin failures++; $display("FAIL rstmid_ldac_n got=%0b exp=1", dac_ldac_n); end
        checks++; if (dac_mosi !== 1'b0) begin failures++; $display("FAIL rstmid_mosi got=%0b exp=0", dac_mosi); end
        l0 = mon_ldac;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bus_read(2'(r), rd);
            checks++;
            if (rd !== exp_regs[r]) begin failures++; $display("FAIL rstmid_reg%0d got=%h exp=%h", r, rd, exp_regs[r]); end
        end
        repeat (300) @(negedge clk);
        checks++; if (mon_ldac !== l0) begin failures++; $display("FAIL rstmid_ldac_pulse got=%0d exp=%0d", mon_ldac, l0); end
        checks++; if (sck_bad !== 0) begin failures++; $display("FAIL sck_outside_cs got=%0d exp=0", sck_bad); end
    endtask

    initial begin
        resetn = 1'b0;
        wstrb = 4'd0;
        addr = 32'd0;
        wdata = 32'd0;
        sample = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_frame();
        test_sample_format();
        test_random_frames();
        test_latch_boundary();
        test_overrun();
        test_en_clear();
        test_div_change();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_spi_out.md
DAC_SPI_OUT -- requirements
Module: dac_spi_out

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-002 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port wstrb, input, 4: bus write strobes; any bit set = register write.
REQ-004 SHALL have port addr, input, 32: bus address; addr[3:2] selects register.
REQ-005 SHALL have port wdata, input, 32: bus write data.
REQ-006 SHALL have port rdata, output, 32: combinational read of register selected by addr[3:2].
REQ-007 SHALL have port sample, input, 32: waveform sample from wave generator output, unsigned.
REQ-008 SHALL have ports dac_cs_n, dac_sck, dac_mosi, dac_ldac_n, output, 1 each: SPI link to 12-bit DAC.

Function
REQ-009 SHALL decode registers: 0 CTRL {bit0 EN, bit1 BUF, bit2 GA_N}; 1 DIV [7:0]; 2 RATE [15:0]; 3 STATUS read-only {bit0 busy, [15:8] overrun count}; writes to 3 clear overrun count.
REQ-010 SHALL run a rate counter while EN=1, issuing one tick every max(RATE,1) clk cycles; RATE write or EN 0->1 restarts counter at 0.
REQ-011 SHALL, on tick with FSM in IDLE, capture sample and build frame {0, BUF, GA_N, 1, data[11:0]} in the same cycle and enter SHIFT next cycle.
REQ-012 SHALL, on tick with FSM not IDLE, drop the sample and increment overrun count, saturating at 255.
REQ-013 SHALL implement FSM IDLE -> SHIFT -> HOLD -> LATCH -> IDLE.
REQ-014 SHALL latch DIV at frame start; half SCK period = DIV+1 clk cycles; DIV changes mid-frame affect next frame only.
REQ-015 SHIFT: dac_cs_n=0; 16 bits MSB first; dac_mosi valid one half-period before each dac_sck rising edge; dac_sck idle low, ends low after 16th falling edge.
REQ-016 HOLD: dac_cs_n=1, dac_sck=0, for DIV+1 cycles.
REQ-017 LATCH: dac_ldac_n=0 for DIV+1 cycles, then IDLE.
REQ-018 busy SHALL be 1 in any state except IDLE.
REQ-019 EN cleared mid-frame SHALL let current frame complete through LATCH; no further ticks.
REQ-020 Tick coinciding with return to IDLE (LATCH last cycle) SHALL count as overrun.
REQ-021 Simultaneous bus write and tick SHALL apply write and tick both; tick uses pre-write CTRL.

Reset
REQ-022 resetn low SHALL immediately force dac_cs_n=1, dac_sck=0, dac_mosi=0, dac_ldac_n=1, FSM IDLE.
REQ-023 Reset SHALL set EN=0, BUF=0, GA_N=1, DIV=1, RATE=1000, overrun=0, rate counter=0.
REQ-024 Reset mid-frame SHALL abort frame; no LDAC pulse issued.

Configuration
REQ-025 Macro DAC_SPI_SAT_EN defined: data = sample>4095 ? 4095 : sample[11:0].
REQ-026 Macro DAC_SPI_SAT_EN undefined: data = sample[11:0] (wrap), no compare logic.

Verification
REQ-027 EN=1, DIV=1, RATE=200, GA_N=1, BUF=0, sample=0xABC -> frame bits 0x3ABC MSB first, SCK period 4 clk, cs_n low 64 clk, ldac_n low 2 clk, frame every 200 clk.
REQ-028 RATE=20, DIV=3 (frame >128 clk) -> STATUS overrun increments each dropped tick, saturates at 255; STATUS write -> 0.
REQ-029 sample=0x00001234 -> data 0xFFF with DAC_SPI_SAT_EN, 0x234 without.
REQ-030 EN cleared at bit 5 of frame -> frame finishes, ldac_n pulses once, then lines idle, busy=0.
REQ-031 resetn low at bit 8 -> cs_n=1, sck=0, ldac_n=1 same cycle asynchronously; registers read reset values.
REQ-032 DIV written 1->7 mid-frame -> current frame SCK period 4 clk, next frame 16 clk.
